// File: rtl/alt_pattern_checker.sv
// Receive-side checker for an alternating two-word ring pattern: hunts for either seed word,
// confirms strict alternation to lock, then flags, counts and flywheels through deviations.
module alt_pattern_checker #(
    parameter int             N        = 8,
    parameter logic [N-1:0]   INI0     = 8'b01010101,
    parameter logic [N-1:0]   INI1     = 8'b10101010,
    parameter int             LOCK_CNT = 4,
    parameter int             LOSS_CNT = 2,
    parameter int             ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N-1:0]     din,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [N-1:0]     expect_o
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);

    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
    localparam logic [MW-1:0] LOSS_V = MW'(LOSS_CNT);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [GW-1:0]    good_cnt_q,  good_cnt_d;
    logic [MW-1:0]    miss_cnt_q,  miss_cnt_d;
    logic [N-1:0]     expect_q,    expect_d;
    logic             locked_q,    locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic             is_pat;
    logic             is_match;
    logic [GW-1:0]    good_inc;
    logic [MW-1:0]    miss_inc;

    // Partner word of a seed; anything that is not INI0 maps to INI0's partner's partner.
    function automatic logic [N-1:0] partner(input logic [N-1:0] w);
        return (w == INI0) ? INI1 : INI0;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    assign is_pat   = (din == INI0) || (din == INI1);
    assign is_match = (din == expect_q);
    assign good_inc = good_cnt_q + GW'(1);
    assign miss_inc = miss_cnt_q + MW'(1);

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        expect_d    = expect_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (tick) begin
            case (state_q)
                HUNT: begin
                    if (is_pat) begin
                        expect_d   = partner(din);
                        good_cnt_d = GW'(1);
                        state_d    = SYNC;
                    end
                end
                SYNC: begin
                    if (is_match) begin
                        expect_d   = partner(expect_q);
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_V) begin
                            state_d    = LOCKED;
                            locked_d   = 1'b1;
                            miss_cnt_d = '0;
                            good_cnt_d = '0;
                        end
                    end else if (is_pat) begin
                        // A seed word out of order restarts confirmation from this sample.
                        expect_d   = partner(din);
                        good_cnt_d = GW'(1);
                    end else begin
                        state_d    = HUNT;
                        expect_d   = INI0;
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the expected word advances whether or not this sample matched.
                    expect_d = partner(expect_q);
                    if (is_match) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_count_d = sat_inc(err_count_q);
                        miss_cnt_d  = miss_inc;
                        if (miss_inc == LOSS_V) begin
                            state_d    = HUNT;
                            locked_d   = 1'b0;
                            expect_d   = INI0;
                            good_cnt_d = '0;
                            miss_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d    = HUNT;
                    locked_d   = 1'b0;
                    expect_d   = INI0;
                    good_cnt_d = '0;
                    miss_cnt_d = '0;
                end
            endcase
        end

        if (err_clr) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            good_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            expect_q    <= INI0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            expect_q    <= expect_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign expect_o  = expect_q;

endmodule

// File: tb/tb_alt_pattern_checker.sv
// Bench for alt_pattern_checker: a sample-level model of lock/flywheel behaviour checked every
// cycle against two instances (8-bit and 2-bit error counters), plus directed literal checks.
module tb_alt_pattern_checker;

    localparam logic [7:0] INI0     = 8'h55;
    localparam logic [7:0] INI1     = 8'hAA;
    localparam int         LOCK_CNT = 4;
    localparam int         LOSS_CNT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] din = 8'h00;
    logic       err_clr = 1'b0;

    logic       locked8, pulse8, locked2, pulse2;
    logic [7:0] count8, exp8, exp2;
    logic [1:0] count2;

    int n_tests = 0;
    int n_fail  = 0;

    alt_pattern_checker #(.N(8), .INI0(INI0), .INI1(INI1), .LOCK_CNT(LOCK_CNT),
                          .LOSS_CNT(LOSS_CNT), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .din(din), .err_clr(err_clr),
        .locked(locked8), .err_pulse(pulse8), .err_count(count8), .expect_o(exp8));

    alt_pattern_checker #(.N(8), .INI0(INI0), .INI1(INI1), .LOCK_CNT(LOCK_CNT),
                          .LOSS_CNT(LOSS_CNT), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .din(din), .err_clr(err_clr),
        .locked(locked2), .err_pulse(pulse2), .err_count(count2), .expect_o(exp2));

    always #5 clk = ~clk;

    // Model: lock after LOCK_CNT samples forming an alternating run of seed words.
    int         m_locked = 0;
    int         m_run    = 0;
    int         m_miss   = 0;
    logic [7:0] m_exp    = INI0;
    int         m_pulse  = 0;
    int         m_cnt8   = 0;
    int         m_cnt2   = 0;

    task automatic model_step();
        if (rst) begin
            m_locked = 0; m_run = 0; m_miss = 0; m_exp = INI0;
            m_pulse = 0; m_cnt8 = 0; m_cnt2 = 0;
            return;
        end
        m_pulse = 0;
        if (tick) begin
            if (m_locked == 0) begin
                if (din == INI0 || din == INI1) begin
                    if (m_run > 0 && din == m_exp) m_run = m_run + 1;
                    else m_run = 1;
                    m_exp = (din == INI0) ? INI1 : INI0;
                    if (m_run == LOCK_CNT) begin
                        m_locked = 1;
                        m_miss = 0;
                    end
                end else begin
                    m_run = 0;
                    m_exp = INI0;
                end
            end else begin
                if (din == m_exp) begin
                    m_miss = 0;
                end else begin
                    m_pulse = 1;
                    m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                    m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
                    m_miss = m_miss + 1;
                end
                m_exp = (m_exp == INI0) ? INI1 : INI0;
                if (m_miss == LOSS_CNT) begin
                    m_locked = 0; m_run = 0; m_miss = 0; m_exp = INI0;
                end
            end
        end
        if (err_clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests = n_tests + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        check("locked8",   32'(locked8), 32'(m_locked));
        check("pulse8",    32'(pulse8),  32'(m_pulse));
        check("count8",    32'(count8),  32'(m_cnt8));
        check("expect8",   32'(exp8),    32'(m_exp));
        check("locked2",   32'(locked2), 32'(m_locked));
        check("pulse2",    32'(pulse2),  32'(m_pulse));
        check("count2",    32'(count2),  32'(m_cnt2));
        check("expect2",   32'(exp2),    32'(m_exp));
    end

    task automatic do_tick(input logic [7:0] d, input logic clr);
        @(negedge clk);
        tick = 1'b1; din = d; err_clr = clr;
        @(negedge clk);
        tick = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_locked", 32'(locked8), 32'd0);
        check("rst_expect", 32'(exp8),    32'h55);
        check("rst_count",  32'(count8),  32'd0);
        check("rst_pulse",  32'(pulse8),  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: acquire lock
        do_tick(8'h55, 1'b0); do_tick(8'hAA, 1'b0); do_tick(8'h55, 1'b0);
        check("t1_not_yet", 32'(locked8), 32'd0);
        do_tick(8'hAA, 1'b0);
        check("t1_locked", 32'(locked8), 32'd1);
        check("t1_expect", 32'(exp8),    32'h55);
        check("t1_model",  32'(m_locked), 32'd1);

        // 2: single error while locked
        do_tick(8'h55, 1'b0); do_tick(8'hAA, 1'b0); do_tick(8'hFF, 1'b0);
        check("t2_pulse", 32'(pulse8), 32'd1);
        check("t2_count", 32'(count8), 32'd1);
        do_tick(8'hAA, 1'b0); do_tick(8'h55, 1'b0);
        check("t2_locked", 32'(locked8), 32'd1);
        check("t2_expect", 32'(exp8),    32'hAA);

        // 3: loss of lock
        do_tick(8'hAA, 1'b0);
        do_tick(8'h55, 1'b0); do_tick(8'h00, 1'b0);
        check("t3_still_locked", 32'(locked8), 32'd1);
        do_tick(8'h00, 1'b0);
        check("t3_locked", 32'(locked8), 32'd0);
        check("t3_pulse",  32'(pulse8),  32'd1);
        check("t3_count",  32'(count8),  32'd3);
        check("t3_expect", 32'(exp8),    32'h55);

        // 4: garbage in SYNC returns to hunt without counting
        do_tick(8'h55, 1'b0); do_tick(8'hAA, 1'b0); do_tick(8'h12, 1'b0);
        check("t4_pulse",  32'(pulse8), 32'd0);
        check("t4_count",  32'(count8), 32'd3);
        check("t4_expect", 32'(exp8),   32'h55);

        // reseed in SYNC: 55,55 restarts, then three more alternating samples lock
        do_tick(8'h55, 1'b0); do_tick(8'h55, 1'b0);
        do_tick(8'hAA, 1'b0); do_tick(8'h55, 1'b0);
        check("reseed_not_yet", 32'(locked8), 32'd0);
        do_tick(8'hAA, 1'b0);
        check("reseed_locked", 32'(locked8), 32'd1);

        // 5: saturation with ERR_W=2, then clear coinciding with an error
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("clr_count", 32'(count8), 32'd0);
        for (int i = 0; i < 5; i++) begin
            do_tick(8'h00, 1'b0);
            do_tick(exp8, 1'b0);
        end
        check("t5_count2", 32'(count2), 32'd3);
        check("t5_count8", 32'(count8), 32'd5);
        check("t5_locked", 32'(locked2), 32'd1);
        do_tick(8'h00, 1'b1);
        check("t5_clr_count2", 32'(count2), 32'd0);
        check("t5_clr_count8", 32'(count8), 32'd0);
        check("t5_clr_pulse",  32'(pulse2), 32'd1);
        do_tick(8'hAA, 1'b0);
        repeat (3) @(negedge clk);
        check("idle_locked", 32'(locked8), 32'd1);
        check("idle_expect", 32'(exp8),    32'h55);

        // 6: asynchronous reset between edges while locked and pulsing
        @(negedge clk);
        tick = 1'b1; din = 8'h00;
        @(posedge clk);
        #2;
        tick = 1'b0;
        check("t6_pre_pulse", 32'(pulse8), 32'd1);
        check("t6_pre_count", 32'(count8), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_locked", 32'(locked8), 32'd0);
        check("t6_count",  32'(count8),  32'd0);
        check("t6_pulse",  32'(pulse8),  32'd0);
        check("t6_expect", 32'(exp8),    32'h55);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
